// File: rtl/rr_mux_arbiter_4.sv
// Four-requester round-robin arbiter with a registered W-bit output word
// and a valid/ready handshake toward the downstream side.
module rr_mux_arbiter_4 #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [3:0]   gnt,
  output logic [1:0]   sel
);

  localparam int unsigned N_REQ = 4;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [1:0]   ptr_q,   ptr_d;
  logic [1:0]   sel_q,   sel_d;
  logic [3:0]   gnt_q,   gnt_d;
  logic [W-1:0] data_q,  data_d;

  logic         xfer_c;
  logic [1:0]   arb_ptr_c;
  logic         arb_found_c;
  logic [1:0]   arb_idx_c;
  logic [W-1:0] arb_data_c;

  // A transfer moves the search start just past the word being accepted.
  always_comb begin
    xfer_c    = (state_q == S_BUSY) && out_ready;
    arb_ptr_c = xfer_c ? (sel_q + 2'd1) : ptr_q;
  end

  // Cyclic first-set search over req starting at arb_ptr_c.
  always_comb begin
    arb_found_c = 1'b0;
    arb_idx_c   = 2'd0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (!arb_found_c && req[arb_ptr_c + 2'(k)]) begin
        arb_found_c = 1'b1;
        arb_idx_c   = arb_ptr_c + 2'(k);
      end
    end
  end

  // Data mux for the winning requester.
  always_comb begin
    arb_data_c = d0;
    case (arb_idx_c)
      2'd0:    arb_data_c = d0;
      2'd1:    arb_data_c = d1;
      2'd2:    arb_data_c = d2;
      default: arb_data_c = d3;
    endcase
  end

  // Next-state logic: load a winner from IDLE or on a transfer, else hold.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (arb_found_c) begin
          state_d = S_BUSY;
          sel_d   = arb_idx_c;
          gnt_d   = 4'b0001 << arb_idx_c;
          data_d  = arb_data_c;
        end
      end
      default: begin
        if (xfer_c) begin
          ptr_d = arb_ptr_c;
          if (arb_found_c) begin
            sel_d  = arb_idx_c;
            gnt_d  = 4'b0001 << arb_idx_c;
            data_d = arb_data_c;
          end else begin
            state_d = S_IDLE;
            gnt_d   = 4'b0000;
          end
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = state_q[0];
  assign out_data  = data_q;
  assign gnt       = gnt_q;
  assign sel       = sel_q;

endmodule
